// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS control logic: opcode and funct values,
// ALUControl codes, ALUOp codes and the multi-cycle controller state encoding.
// No ports; imported by alu_decoder and multicycle_control_fsm.
package mips_pkg;

    // Opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // R-type funct values (IR[5:0])
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    // ALUControl codes
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // ALUOp codes passed from the controller to the ALU decoder
    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_t;

    // Controller states; values are visible on the debug state port
    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11
    } state_t;

    // True for the R-type functions the datapath implements
    function automatic logic funct_supported(input logic [5:0] funct);
        logic ok;
        ok = 1'b0;
        case (funct)
            FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: ok = 1'b1;
            default:                               ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// ALU decoder: maps ALUOp and the R-type funct field to the 3-bit ALUControl.
// Purely combinational so the single-cycle ControlUnit can reuse it.
// Ports:
//   alu_op      in  2  00=add, 01=sub, 10=decode funct
//   funct       in  6  IR[5:0]
//   alu_control out 3  ALU operation select
module alu_decoder
    import mips_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [5:0] funct,
    output logic [2:0] alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_ADD: alu_control = ALU_ADD;
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FN_ADD:  alu_control = ALU_ADD;
                    FN_SUB:  alu_control = ALU_SUB;
                    FN_AND:  alu_control = ALU_AND;
                    FN_OR:   alu_control = ALU_OR;
                    FN_SLT:  alu_control = ALU_SLT;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle MIPS sequencing controller. A Moore FSM over opcode/funct that
// drives every datapath enable and mux select each cycle, with optional wait
// states in FETCH and MEMRD for slow memory.
// Ports:
//   clock, reset           rising-edge clock, synchronous active-high reset
//   opcode, funct          IR[31:26], IR[5:0]
//   PCWrite, Branch        PC load / conditional-branch enables
//   IorD, MemWrite         memory address select / write enable
//   IRWrite                instruction register load
//   MemToReg, RegDst       register write data / address selects
//   RegWrite               register file write enable
//   ALUSrcA, ALUSrcB       ALU operand selects
//   PCSrc                  next-PC select
//   ALUControl             ALU operation
//   instr_done             pulse in the final state of each instruction
//   illegal_op             pulse in DECODE for an unsupported instruction
//   state                  current state (debug)
module multicycle_control_fsm
    import mips_pkg::*;
#(
    parameter int unsigned MEM_WAIT_CYCLES = 0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic       PCWrite,
    output logic       Branch,
    output logic       IorD,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemToReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSrc,
    output logic [2:0] ALUControl,
    output logic       instr_done,
    output logic       illegal_op,
    output logic [3:0] state
);

    localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT_CYCLES);

    state_t     state_q, state_d;
    logic [3:0] wait_cnt_q, wait_cnt_d;
    logic       wait_done;
    logic       illegal_c;

    // Per-state decode before reset gating
    logic       pc_write_c, branch_c, iord_c, mem_write_c, ir_write_c;
    logic       mem_to_reg_c, reg_dst_c, reg_write_c, alu_src_a_c;
    logic [1:0] alu_src_b_c, pc_src_c;
    logic       done_c, alu_en_c;
    logic [1:0] alu_op_c;
    logic [2:0] alu_ctrl;

    assign wait_done = (wait_cnt_q == WAIT_LAST);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_FETCH;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        illegal_c = 1'b0;
        case (state_q)
            S_FETCH: if (wait_done) state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE: begin
                        if (funct_supported(funct)) begin
                            state_d = S_EXECUTE;
                        end else begin
                            state_d   = S_FETCH;
                            illegal_c = 1'b1;
                        end
                    end
                    OP_BEQ:  state_d = S_BRANCH;
                    OP_ADDI: state_d = S_ADDIEX;
                    OP_J:    state_d = S_JUMP;
                    default: begin
                        state_d   = S_FETCH;
                        illegal_c = 1'b1;
                    end
                endcase
            end
            S_MEMADR:  state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   if (wait_done) state_d = S_MEMWB;
            S_EXECUTE: state_d = S_ALUWB;
            S_ADDIEX:  state_d = S_ADDIWB;
            default:   state_d = S_FETCH;
        endcase
    end

    // Every state transition restarts the counter; only FETCH and MEMRD
    // ever self-loop, so this is the "load 0 on entry" behaviour.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (state_d != state_q) begin
            wait_cnt_d = '0;
        end else if (wait_cnt_q < WAIT_LAST) begin
            wait_cnt_d = wait_cnt_q + 4'd1;
        end
    end

    // Moore output decode
    always_comb begin
        pc_write_c   = 1'b0;
        branch_c     = 1'b0;
        iord_c       = 1'b0;
        mem_write_c  = 1'b0;
        ir_write_c   = 1'b0;
        mem_to_reg_c = 1'b0;
        reg_dst_c    = 1'b0;
        reg_write_c  = 1'b0;
        alu_src_a_c  = 1'b0;
        alu_src_b_c  = 2'b00;
        pc_src_c     = 2'b00;
        done_c       = 1'b0;
        alu_en_c     = 1'b0;
        alu_op_c     = ALUOP_ADD;
        case (state_q)
            S_FETCH: begin
                alu_src_b_c = 2'b01;
                alu_en_c    = 1'b1;
                pc_write_c  = wait_done;
                ir_write_c  = wait_done;
            end
            S_DECODE: begin
                alu_src_b_c = 2'b11;
                alu_en_c    = 1'b1;
            end
            S_MEMADR: begin
                alu_src_a_c = 1'b1;
                alu_src_b_c = 2'b10;
                alu_en_c    = 1'b1;
            end
            S_MEMRD: iord_c = 1'b1;
            S_MEMWB: begin
                mem_to_reg_c = 1'b1;
                reg_write_c  = 1'b1;
                done_c       = 1'b1;
            end
            S_MEMWR: begin
                iord_c      = 1'b1;
                mem_write_c = 1'b1;
                done_c      = 1'b1;
            end
            S_EXECUTE: begin
                alu_src_a_c = 1'b1;
                alu_op_c    = ALUOP_FUNCT;
                alu_en_c    = 1'b1;
            end
            S_ALUWB: begin
                reg_dst_c   = 1'b1;
                reg_write_c = 1'b1;
                done_c      = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a_c = 1'b1;
                alu_op_c    = ALUOP_SUB;
                alu_en_c    = 1'b1;
                branch_c    = 1'b1;
                pc_src_c    = 2'b01;
                done_c      = 1'b1;
            end
            S_ADDIEX: begin
                alu_src_a_c = 1'b1;
                alu_src_b_c = 2'b10;
                alu_en_c    = 1'b1;
            end
            S_ADDIWB: begin
                reg_write_c = 1'b1;
                done_c      = 1'b1;
            end
            S_JUMP: begin
                pc_src_c   = 2'b10;
                pc_write_c = 1'b1;
                done_c     = 1'b1;
            end
            default: ;
        endcase
    end

    alu_decoder u_alu_decoder (
        .alu_op      (alu_op_c),
        .funct       (funct),
        .alu_control (alu_ctrl)
    );

    // States that do not use the ALU report ALUControl=000; reset blanks all.
    always_comb begin
        PCWrite    = pc_write_c;
        Branch     = branch_c;
        IorD       = iord_c;
        MemWrite   = mem_write_c;
        IRWrite    = ir_write_c;
        MemToReg   = mem_to_reg_c;
        RegDst     = reg_dst_c;
        RegWrite   = reg_write_c;
        ALUSrcA    = alu_src_a_c;
        ALUSrcB    = alu_src_b_c;
        PCSrc      = pc_src_c;
        ALUControl = alu_en_c ? alu_ctrl : 3'b000;
        instr_done = done_c;
        illegal_op = (state_q == S_DECODE) && illegal_c;
        state      = state_q;
        if (reset) begin
            PCWrite    = 1'b0;
            Branch     = 1'b0;
            IorD       = 1'b0;
            MemWrite   = 1'b0;
            IRWrite    = 1'b0;
            MemToReg   = 1'b0;
            RegDst     = 1'b0;
            RegWrite   = 1'b0;
            ALUSrcA    = 1'b0;
            ALUSrcB    = '0;
            PCSrc      = '0;
            ALUControl = '0;
            instr_done = 1'b0;
            illegal_op = 1'b0;
            state      = '0;
        end
    end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Self-checking bench for multicycle_control_fsm: one instance with no memory
// wait states and one with two, compared cycle by cycle against expected
// output vectors queued when each instruction is issued.
module tb_multicycle_control_fsm;

    logic       clk = 1'b0;
    logic       rst0, rst2;
    logic [5:0] op0, fn0, op2, fn2;

    logic       PCWrite0, Branch0, IorD0, MemWrite0, IRWrite0, MemToReg0, RegDst0, RegWrite0, ALUSrcA0;
    logic [1:0] ALUSrcB0, PCSrc0;
    logic [2:0] ALUControl0;
    logic       instr_done0, illegal_op0;
    logic [3:0] state0;

    logic       PCWrite2, Branch2, IorD2, MemWrite2, IRWrite2, MemToReg2, RegDst2, RegWrite2, ALUSrcA2;
    logic [1:0] ALUSrcB2, PCSrc2;
    logic [2:0] ALUControl2;
    logic       instr_done2, illegal_op2;
    logic [3:0] state2;

    logic [21:0] vec0, vec2;
    logic [21:0] exp_q[$];
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    multicycle_control_fsm #(.MEM_WAIT_CYCLES(0)) dut0 (
        .clock(clk), .reset(rst0), .opcode(op0), .funct(fn0),
        .PCWrite(PCWrite0), .Branch(Branch0), .IorD(IorD0), .MemWrite(MemWrite0),
        .IRWrite(IRWrite0), .MemToReg(MemToReg0), .RegDst(RegDst0), .RegWrite(RegWrite0),
        .ALUSrcA(ALUSrcA0), .ALUSrcB(ALUSrcB0), .PCSrc(PCSrc0), .ALUControl(ALUControl0),
        .instr_done(instr_done0), .illegal_op(illegal_op0), .state(state0)
    );

    multicycle_control_fsm #(.MEM_WAIT_CYCLES(2)) dut2 (
        .clock(clk), .reset(rst2), .opcode(op2), .funct(fn2),
        .PCWrite(PCWrite2), .Branch(Branch2), .IorD(IorD2), .MemWrite(MemWrite2),
        .IRWrite(IRWrite2), .MemToReg(MemToReg2), .RegDst(RegDst2), .RegWrite(RegWrite2),
        .ALUSrcA(ALUSrcA2), .ALUSrcB(ALUSrcB2), .PCSrc(PCSrc2), .ALUControl(ALUControl2),
        .instr_done(instr_done2), .illegal_op(illegal_op2), .state(state2)
    );

    assign vec0 = {PCWrite0, Branch0, IorD0, MemWrite0, IRWrite0, MemToReg0, RegDst0, RegWrite0,
                   ALUSrcA0, ALUSrcB0, PCSrc0, ALUControl0, instr_done0, illegal_op0, state0};
    assign vec2 = {PCWrite2, Branch2, IorD2, MemWrite2, IRWrite2, MemToReg2, RegDst2, RegWrite2,
                   ALUSrcA2, ALUSrcB2, PCSrc2, ALUControl2, instr_done2, illegal_op2, state2};

    function automatic bit fn_legal(input logic [5:0] fn);
        return (fn == 6'b100000) || (fn == 6'b100010) || (fn == 6'b100100) ||
               (fn == 6'b100101) || (fn == 6'b101010);
    endfunction

    function automatic logic [2:0] fn_alu(input logic [5:0] fn);
        case (fn)
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    // Expected output vector for one cycle spent in state st
    function automatic logic [21:0] model(input int st, input bit last, input logic [5:0] fn, input bit ill);
        logic pcw, br, iord, mw, irw, m2r, rd, rw, srca, done, illo;
        logic [1:0] srcb, pcsrc;
        logic [2:0] alc;
        {pcw, br, iord, mw, irw, m2r, rd, rw, srca, done, illo} = '0;
        srcb = 2'b00; pcsrc = 2'b00; alc = 3'b000;
        case (st)
            0:  begin srcb = 2'b01; alc = 3'b010; pcw = last; irw = last; end
            1:  begin srcb = 2'b11; alc = 3'b010; illo = ill; end
            2:  begin srca = 1'b1; srcb = 2'b10; alc = 3'b010; end
            3:  iord = 1'b1;
            4:  begin m2r = 1'b1; rw = 1'b1; done = 1'b1; end
            5:  begin iord = 1'b1; mw = 1'b1; done = 1'b1; end
            6:  begin srca = 1'b1; alc = fn_alu(fn); end
            7:  begin rd = 1'b1; rw = 1'b1; done = 1'b1; end
            8:  begin srca = 1'b1; alc = 3'b110; br = 1'b1; pcsrc = 2'b01; done = 1'b1; end
            9:  begin srca = 1'b1; srcb = 2'b10; alc = 3'b010; end
            10: begin rw = 1'b1; done = 1'b1; end
            11: begin pcsrc = 2'b10; pcw = 1'b1; done = 1'b1; end
            default: ;
        endcase
        return {pcw, br, iord, mw, irw, m2r, rd, rw, srca, srcb, pcsrc, alc, done, illo, 4'(st)};
    endfunction

    // Queue the expected per-cycle vectors for one instruction
    task automatic push_instr(input logic [5:0] op, input logic [5:0] fn, input int w);
        for (int i = 0; i <= w; i++) exp_q.push_back(model(0, i == w, fn, 1'b0));
        case (op)
            6'b100011: begin
                exp_q.push_back(model(1, 0, fn, 0));
                exp_q.push_back(model(2, 0, fn, 0));
                for (int i = 0; i <= w; i++) exp_q.push_back(model(3, 0, fn, 0));
                exp_q.push_back(model(4, 0, fn, 0));
            end
            6'b101011: begin
                exp_q.push_back(model(1, 0, fn, 0));
                exp_q.push_back(model(2, 0, fn, 0));
                exp_q.push_back(model(5, 0, fn, 0));
            end
            6'b000000: begin
                if (fn_legal(fn)) begin
                    exp_q.push_back(model(1, 0, fn, 0));
                    exp_q.push_back(model(6, 0, fn, 0));
                    exp_q.push_back(model(7, 0, fn, 0));
                end else begin
                    exp_q.push_back(model(1, 0, fn, 1));
                end
            end
            6'b000100: begin
                exp_q.push_back(model(1, 0, fn, 0));
                exp_q.push_back(model(8, 0, fn, 0));
            end
            6'b001000: begin
                exp_q.push_back(model(1, 0, fn, 0));
                exp_q.push_back(model(9, 0, fn, 0));
                exp_q.push_back(model(10, 0, fn, 0));
            end
            6'b000010: begin
                exp_q.push_back(model(1, 0, fn, 0));
                exp_q.push_back(model(11, 0, fn, 0));
            end
            default: exp_q.push_back(model(1, 0, fn, 1));
        endcase
    endtask

    task automatic test_reset;
        rst0 = 1'b1; rst2 = 1'b1;
        op0 = 6'b100011; fn0 = 6'b100000; op2 = 6'b101011; fn2 = 6'b100000;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        checks++;
        if (vec0 !== 22'h0) begin
            failures++; $display("FAIL reset_w0_outputs got=%h exp=%h", vec0, 22'h0);
        end
        checks++;
        if (vec2 !== 22'h0) begin
            failures++; $display("FAIL reset_w2_outputs got=%h exp=%h", vec2, 22'h0);
        end
        rst0 = 1'b0;
        #1;
        checks++;
        if (vec0 !== model(0, 1, fn0, 0)) begin
            failures++; $display("FAIL reset_release_fetch got=%h exp=%h", vec0, model(0, 1, fn0, 0));
        end
        checks++;
        if (vec2 !== 22'h0) begin
            failures++; $display("FAIL reset_w2_held got=%h exp=%h", vec2, 22'h0);
        end
    endtask

    task automatic test_lw;
        logic [21:0] e;
        int n = 0, dn = 0, rw_cyc = -1;
        op0 = 6'b100011; fn0 = 6'b000000;
        push_instr(op0, fn0, 0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (vec0 !== e) begin
                failures++; $display("FAIL lw_cycle%0d got=%h exp=%h", n, vec0, e);
            end
            if (RegWrite0 && MemToReg0) rw_cyc = n;
            dn += int'(instr_done0);
            n++;
            @(negedge clk); #1;
        end
        checks++;
        if (rw_cyc !== 4) begin
            failures++; $display("FAIL lw_regwrite_cycle got=%0d exp=4", rw_cyc);
        end
        checks++;
        if (dn !== 1) begin
            failures++; $display("FAIL lw_instr_done_count got=%0d exp=1", dn);
        end
    endtask

    task automatic test_rtype_back_to_back;
        logic [5:0] fns[4] = '{6'b100000, 6'b100010, 6'b101010, 6'b100101};
        logic [21:0] e;
        int n;
        op0 = 6'b000000;
        foreach (fns[k]) begin
            fn0 = fns[k];
            push_instr(op0, fn0, 0);
            n = 0;
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (vec0 !== e) begin
                    failures++; $display("FAIL rtype_fn%b_cycle%0d got=%h exp=%h", fns[k], n, vec0, e);
                end
                n++;
                @(negedge clk); #1;
            end
        end
    endtask

    task automatic test_branch_jump_addi;
        logic [5:0] ops[3] = '{6'b000100, 6'b000010, 6'b001000};
        logic [21:0] e;
        int n, dn;
        fn0 = 6'b101010;
        foreach (ops[k]) begin
            op0 = ops[k];
            push_instr(op0, fn0, 0);
            n = 0; dn = 0;
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (vec0 !== e) begin
                    failures++; $display("FAIL op%b_cycle%0d got=%h exp=%h", ops[k], n, vec0, e);
                end
                dn += int'(instr_done0);
                n++;
                @(negedge clk); #1;
            end
            checks++;
            if (dn !== 1) begin
                failures++; $display("FAIL op%b_done_count got=%0d exp=1", ops[k], dn);
            end
        end
    endtask

    task automatic test_illegal;
        logic [5:0] ops[2] = '{6'b111111, 6'b000000};
        logic [21:0] e;
        int n, il, wr;
        fn0 = 6'b000001;
        foreach (ops[k]) begin
            op0 = ops[k];
            push_instr(op0, fn0, 0);
            n = 0; il = 0; wr = 0;
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (vec0 !== e) begin
                    failures++; $display("FAIL illegal_op%b_cycle%0d got=%h exp=%h", ops[k], n, vec0, e);
                end
                il += int'(illegal_op0);
                wr += int'(RegWrite0) + int'(MemWrite0);
                n++;
                @(negedge clk); #1;
            end
            checks++;
            if (il !== 1 || wr !== 0) begin
                failures++; $display("FAIL illegal_op%b_pulse got=%0d/%0d exp=1/0", ops[k], il, wr);
            end
            checks++;
            if (state0 !== 4'd0) begin
                failures++; $display("FAIL illegal_op%b_return got=%0d exp=0", ops[k], state0);
            end
        end
    endtask

    task automatic test_reset_mid;
        logic [21:0] e;
        int n = 0;
        op0 = 6'b100011; fn0 = 6'b000000;
        push_instr(op0, fn0, 0);
        while (n < 4) begin
            e = exp_q.pop_front();
            checks++;
            if (vec0 !== e) begin
                failures++; $display("FAIL midrst_cycle%0d got=%h exp=%h", n, vec0, e);
            end
            n++;
            if (n < 4) begin
                @(negedge clk); #1;
            end
        end
        exp_q.delete();
        rst0 = 1'b1;
        #1;
        checks++;
        if (vec0 !== 22'h0) begin
            failures++; $display("FAIL midrst_forced_zero got=%h exp=%h", vec0, 22'h0);
        end
        @(negedge clk); #1;
        checks++;
        if (RegWrite0 !== 1'b0) begin
            failures++; $display("FAIL midrst_regwrite got=%b exp=0", RegWrite0);
        end
        rst0 = 1'b0;
        #1;
        checks++;
        if (vec0 !== model(0, 1, fn0, 0)) begin
            failures++; $display("FAIL midrst_fetch got=%h exp=%h", vec0, model(0, 1, fn0, 0));
        end
    endtask

    task automatic test_sw_wait;
        logic [21:0] e;
        int n = 0, pcw = 0, pcw_cyc = -1, mw = 0;
        op2 = 6'b101011; fn2 = 6'b000000;
        rst2 = 1'b0;
        #1;
        push_instr(op2, fn2, 2);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (vec2 !== e) begin
                failures++; $display("FAIL sw_w2_cycle%0d got=%h exp=%h", n, vec2, e);
            end
            if (PCWrite2) begin pcw++; pcw_cyc = n; end
            mw += int'(MemWrite2);
            n++;
            @(negedge clk); #1;
        end
        checks++;
        if (pcw !== 1 || pcw_cyc !== 2) begin
            failures++; $display("FAIL sw_w2_pcwrite got=%0d@%0d exp=1@2", pcw, pcw_cyc);
        end
        checks++;
        if (mw !== 1) begin
            failures++; $display("FAIL sw_w2_memwrite got=%0d exp=1", mw);
        end
        checks++;
        if (state2 !== 4'd0 || n !== 6) begin
            failures++; $display("FAIL sw_w2_total got=state%0d/%0d exp=state0/6", state2, n);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_lw();
        test_rtype_back_to_back();
        test_branch_jump_addi();
        test_illegal();
        test_reset_mid();
        test_sw_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
